cache_ram_controller: RTL and testbench

- Backing-memory stage directly downstream of the cache control unit.
- Services its line-level RAM read/write requests (RAM_RD / RAM_WR levels) by moving one cache line word-by-word to or from an internal storage array.
- Each word access is modelled with a fixed access latency.
- Returns a one-cycle RAM_ACK pulse when the whole line transfer is complete. The cache control FSM advances on that pulse.

---
 rtl/cache_ram_pkg.sv | 21 ++
 rtl/ram_line_array.sv | 23 ++
 rtl/cache_ram_controller.sv | 124 ++++++++++++
 tb/tb_cache_ram_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ram_pkg.sv
// Shared definitions for the cache backing-memory controller: FSM state
// encoding, default line geometry and a counter-width helper.
package cache_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 3;

  // Counters never collapse to zero bits, even for a range of one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_line_array.sv
// Word-addressed backing store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ram_line_array #(
  parameter int WADDR_W = 10,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [WADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cache_ram_controller.sv
// Line-level RAM stage behind the cache control unit: moves one cache line
// word-by-word to/from the backing array and pulses OUT_RAM_ACK when done.
module cache_ram_controller
  import cache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                             IN_CLK,
  input  logic                             IN_RESET,
  input  logic                             IN_RAM_RD,
  input  logic                             IN_RAM_WR,
  input  logic [ADDR_WIDTH-1:0]            IN_ADDR,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] IN_LINE_DATA,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] OUT_LINE_DATA,
  output logic                             OUT_RAM_ACK,
  output logic                             OUT_BUSY,
  output logic [1:0]                       OUT_DBG_STATE
);

  localparam int LINE_W  = LINE_WORDS * DATA_WIDTH;
  localparam int LAT_W   = cnt_width(LATENCY);
  localparam int IDX_W   = cnt_width(LINE_WORDS);
  localparam int WADDR_W = ADDR_WIDTH + $clog2(LINE_WORDS);
  localparam int DEPTH   = (2 ** ADDR_WIDTH) * LINE_WORDS;

  // Handshake: IN_RAM_RD / IN_RAM_WR are levels sampled only in IDLE; address,
  // line data and direction are latched there, so later input changes are
  // ignored. OUT_RAM_ACK is high for exactly the one cycle spent in ACK.
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]       wline_q, wline_d;
  logic [LINE_W-1:0]       rline_q, rline_d;
  logic                    rd_q, rd_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LAT_W-1:0]        lat_q, lat_d;

  logic                    lat_done;
  logic                    last_word;
  logic                    mem_we;
  logic [WADDR_W-1:0]      word_addr;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign lat_done  = (lat_q == LAT_W'(LATENCY - 1));
  assign last_word = (idx_q == IDX_W'(LINE_WORDS - 1));
  assign mem_we    = (state_q == ST_BUSY) && lat_done && !rd_q;
  assign word_addr = WADDR_W'(addr_q) * WADDR_W'(LINE_WORDS) + WADDR_W'(idx_q);
  assign mem_wdata = wline_q[idx_q*DATA_WIDTH +: DATA_WIDTH];

  ram_line_array #(
    .WADDR_W (WADDR_W),
    .DATA_W  (DATA_WIDTH),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk_i   (IN_CLK),
    .we_i    (mem_we),
    .addr_i  (word_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_RAM_RD || IN_RAM_WR) begin
          addr_d  = IN_ADDR;
          wline_d = IN_LINE_DATA;
          rd_d    = IN_RAM_RD;   // read wins when both are raised
          idx_d   = '0;
          lat_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (lat_done) begin
          lat_d = '0;
          if (rd_q) rline_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          if (last_word) state_d = ST_ACK;
          else           idx_d   = idx_q + IDX_W'(1);
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLK or posedge IN_RESET) begin
    if (IN_RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
    end
  end

  assign OUT_LINE_DATA = rline_q;
  assign OUT_RAM_ACK   = (state_q == ST_ACK);
  assign OUT_BUSY      = (state_q != ST_IDLE);
  assign OUT_DBG_STATE = state_q;

endmodule

// File: tb/tb_cache_ram_controller.sv
// Directed bench for cache_ram_controller: vector table of line transfers plus
// hand-written back-to-back, dropped-request and reset-abort sequences.
module tb_cache_ram_controller;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LWD = 4;
  localparam int LAT = 3;
  localparam int LW  = LWD * DW;
  localparam int EXP_LAT = LAT * LWD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wline = '0;
  logic [LW-1:0] rline;
  logic          ack;
  logic          busy;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  cache_ram_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LINE_WORDS (LWD),
    .LATENCY    (LAT)
  ) dut (
    .IN_CLK        (clk),
    .IN_RESET      (rst),
    .IN_RAM_RD     (rd),
    .IN_RAM_WR     (wr),
    .IN_ADDR       (addr),
    .IN_LINE_DATA  (wline),
    .OUT_LINE_DATA (rline),
    .OUT_RAM_ACK   (ack),
    .OUT_BUSY      (busy),
    .OUT_DBG_STATE (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: raise a request, wait for acceptance and the ACK pulse
  task automatic run_line(input string tag, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [LW-1:0] d,
                          input bit drop, output int acc_edges,
                          output int lat_edges, output logic [LW-1:0] line);
    rd = r; wr = w; addr = a; wline = d;
    acc_edges = 0;
    do begin
      tick();
      acc_edges++;
    end while (!busy && acc_edges < 4);
    chk({tag, "_busy"}, LW'(busy), LW'(1));
    if (drop) begin
      rd = 1'b0;
      wr = 1'b0;
    end
    addr  = a ^ 8'hFF;
    wline = ~d;
    lat_edges = 0;
    while (!ack && lat_edges < 60) begin
      tick();
      lat_edges++;
    end
    rd = 1'b0;
    wr = 1'b0;
    line = rline;
    chk({tag, "_ack_seen"}, LW'(ack), LW'(1));
  endtask

  typedef struct {
    logic          r;
    logic          w;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [LW-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [LW-1:0] l5, l7, l3, l11, l12, l9_new, l9_exp, junk;

  initial begin
    int acc, lat, ack_cnt, busy_cnt;
    logic [LW-1:0] got;

    l5     = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    l7     = {32'hDDDD_0007, 32'hCCCC_0007, 32'hBBBB_0007, 32'hAAAA_0007};
    l3     = {32'h3333_0003, 32'h2222_0003, 32'h1111_0003, 32'h0000_0003};
    l11    = {32'h1111_B004, 32'h1111_B003, 32'h1111_B002, 32'h1111_B001};
    l12    = {32'hC0C0_0004, 32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001};
    l9_new = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    l9_exp = {32'h0000_0000, 32'h0000_0000, 32'h0000_0002, 32'h0000_0001};
    junk   = 128'hDEAD_BEEF_0BAD_F00D_FEED_FACE_CAFE_BABE;

    //          r     w     a      d          exp (OUT_LINE_DATA at ACK)
    vecs[0] = '{1'b0, 1'b1, 8'd5,  l5,        '0};
    vecs[1] = '{1'b1, 1'b0, 8'd5,  junk,      l5};
    vecs[2] = '{1'b0, 1'b1, 8'd7,  l7,        l5};
    vecs[3] = '{1'b1, 1'b0, 8'd7,  junk,      l7};
    vecs[4] = '{1'b0, 1'b1, 8'd3,  l3,        l7};
    vecs[5] = '{1'b1, 1'b1, 8'd3,  junk,      l3};
    vecs[6] = '{1'b1, 1'b0, 8'd3,  '0,        l3};
    vecs[7] = '{1'b0, 1'b1, 8'd9,  '0,        l3};

    // reset state
    tick();
    tick();
    chk("reset_ack",  LW'(ack),  '0);
    chk("reset_busy", LW'(busy), '0);
    chk("reset_line", rline,     '0);
    chk("reset_state", LW'(dbg_state), '0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_line($sformatf("v%0d", i), vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d,
               1'b0, acc, lat, got);
      chk($sformatf("v%0d_latency", i), LW'(lat), LW'(EXP_LAT));
      chk($sformatf("v%0d_line", i), got, vecs[i].exp);
      tick();
      chk($sformatf("v%0d_ack_one_cycle", i), LW'(ack), '0);
      chk($sformatf("v%0d_idle", i), LW'(busy), '0);
    end

    // back-to-back: write raised during the read ACK cycle
    run_line("b2b_rd", 1'b1, 1'b0, 8'd7, junk, 1'b0, acc, lat, got);
    chk("b2b_rd_line", got, l7);
    run_line("b2b_wr", 1'b0, 1'b1, 8'd11, l11, 1'b0, acc, lat, got);
    chk("b2b_accept_edges", LW'(acc), LW'(2));
    chk("b2b_wr_latency", LW'(lat), LW'(EXP_LAT));
    chk("b2b_wr_line_kept", got, l7);
    tick();
    run_line("b2b_chk", 1'b1, 1'b0, 8'd11, '0, 1'b0, acc, lat, got);
    chk("b2b_readback", got, l11);
    tick();

    // request dropped after one cycle
    run_line("drop", 1'b0, 1'b1, 8'd12, l12, 1'b1, acc, lat, got);
    chk("drop_latency", LW'(lat), LW'(EXP_LAT));
    tick();
    chk("drop_ack_one_cycle", LW'(ack), '0);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("drop_no_second_xfer", LW'(busy_cnt), '0);
    run_line("drop_chk", 1'b1, 1'b0, 8'd12, '0, 1'b0, acc, lat, got);
    chk("drop_readback", got, l12);
    tick();

    // reset mid-write: words 0,1 land (edges 3 and 6), word 2 would land at edge 9
    rd = 1'b0; wr = 1'b1; addr = 8'd9; wline = l9_new;
    tick();
    chk("abort_busy", LW'(busy), LW'(1));
    for (int k = 0; k < 7; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rst_ack",  LW'(ack),  '0);
    chk("abort_rst_busy", LW'(busy), '0);
    chk("abort_rst_line", rline,     '0);
    wr = 1'b0;
    tick();
    rst = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ack) ack_cnt++;
    end
    chk("abort_no_ack", LW'(ack_cnt), '0);
    run_line("abort_chk", 1'b1, 1'b0, 8'd9, '0, 1'b0, acc, lat, got);
    chk("abort_readback", got, l9_exp);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
